// File: rtl/servo_steer_ctrl_pkg.sv
// Shared types and default angle constants for the servo steering slice.
package servo_pkg;

    typedef logic [7:0] angle_t;

    typedef enum logic {
        MANUAL,
        CMD
    } state_t;

    localparam angle_t DEF_CENTER_ANGLE = 8'd90;
    localparam angle_t DEF_POS_ANGLE    = 8'd110;
    localparam angle_t DEF_NEG_ANGLE    = 8'd70;
    localparam angle_t DEF_MIN_ANGLE    = 8'd60;
    localparam angle_t DEF_MAX_ANGLE    = 8'd120;

    function automatic angle_t clamp_angle(input angle_t a, input angle_t lo, input angle_t hi);
        if (a < lo) return lo;
        if (a > hi) return hi;
        return a;
    endfunction

endpackage

// File: rtl/servo_steer_ctrl_if.sv
// Command channel: valid/ready angle handshake plus the release pulse.
interface servo_steer_ctrl_if;
    import servo_pkg::*;

    logic   cmd_valid;
    angle_t cmd_angle;
    logic   cmd_ready;
    logic   cmd_release;

    modport master (output cmd_valid, output cmd_angle, output cmd_release, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_angle, input  cmd_release, output cmd_ready);

endinterface

// File: rtl/servo_steer_ctrl_tick_gen.sv
// Free-running divider: one-cycle tick every CLK_DIV clocks, also used by the PWM block.
module servo_tick_gen #(
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic clk,
    input  logic nrst,
    output logic tick
);

    localparam int unsigned W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/servo_steer_ctrl.sv
// Steering source arbiter (manual vs. command channel) with slew-limited, clamped angle output.
module servo_steer_ctrl
    import servo_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 50000,
    parameter angle_t      STEP         = 8'd1,
    parameter angle_t      MIN_ANGLE    = DEF_MIN_ANGLE,
    parameter angle_t      MAX_ANGLE    = DEF_MAX_ANGLE,
    parameter angle_t      CENTER_ANGLE = DEF_CENTER_ANGLE,
    parameter angle_t      POS_ANGLE    = DEF_POS_ANGLE,
    parameter angle_t      NEG_ANGLE    = DEF_NEG_ANGLE,
    parameter logic [15:0] HOLD_TICKS   = 16'd2000
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              pos_dir,
    input  logic              neg_dir,
    servo_steer_ctrl_if.slave cmd,
    output angle_t            angle,
    output angle_t            target,
    output logic              src_cmd,
    output logic              at_target
);

    state_t      state;
    logic [15:0] hold_cnt;
    logic        tick;
    logic        cmd_ready_q;
    logic        accept;
    logic        release_go;
    logic        to_cmd;
    angle_t      manual_tgt;
    angle_t      cmd_tgt;
    angle_t      target_nx;
    angle_t      angle_nx;
    logic [8:0]  diff_up;
    logic [8:0]  diff_dn;

    servo_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .nrst (nrst),
        .tick (tick)
    );

    assign cmd.cmd_ready = cmd_ready_q;

    always_comb begin
        manual_tgt = pos_dir ? POS_ANGLE : (neg_dir ? NEG_ANGLE : CENTER_ANGLE);
        cmd_tgt    = clamp_angle(cmd.cmd_angle, MIN_ANGLE, MAX_ANGLE);
        accept     = cmd.cmd_valid & cmd_ready_q;
        // Release beats a same-cycle accept; the accepted command is simply dropped.
        release_go = (state == CMD) && (cmd.cmd_release || (hold_cnt >= HOLD_TICKS));
        to_cmd     = accept & ~release_go;

        target_nx = target;
        case (state)
            MANUAL:  target_nx = to_cmd ? cmd_tgt : manual_tgt;
            CMD: begin
                if (release_go)  target_nx = manual_tgt;
                else if (accept) target_nx = cmd_tgt;
            end
            default: target_nx = manual_tgt;
        endcase

        diff_up  = {1'b0, target} - {1'b0, angle};
        diff_dn  = {1'b0, angle} - {1'b0, target};
        angle_nx = angle;
        if (tick) begin
            if (angle < target) begin
                angle_nx = angle + ((diff_up < {1'b0, STEP}) ? diff_up[7:0] : STEP);
            end else if (angle > target) begin
                angle_nx = angle - ((diff_dn < {1'b0, STEP}) ? diff_dn[7:0] : STEP);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= MANUAL;
            angle       <= CENTER_ANGLE;
            target      <= CENTER_ANGLE;
            src_cmd     <= 1'b0;
            at_target   <= 1'b1;
            cmd_ready_q <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            angle     <= angle_nx;
            target    <= target_nx;
            at_target <= (angle_nx == target_nx);
            case (state)
                MANUAL: begin
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        state       <= CMD;
                        src_cmd     <= 1'b1;
                        hold_cnt    <= '0;
                        cmd_ready_q <= (angle_nx == target_nx);
                    end
                end
                CMD: begin
                    if (release_go) begin
                        state       <= MANUAL;
                        src_cmd     <= 1'b0;
                        hold_cnt    <= '0;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        cmd_ready_q <= (angle_nx == target_nx);
                        if (accept)    hold_cnt <= '0;
                        else if (tick) hold_cnt <= hold_cnt + 16'd1;
                    end
                end
                default: state <= MANUAL;
            endcase
        end
    end

endmodule

// File: tb/tb_servo_steer_ctrl.sv
// Directed bench for servo_steer_ctrl with CLK_DIV=4, STEP=2, HOLD_TICKS=5.
module tb_servo_steer_ctrl;

    logic       clk = 1'b0;
    logic       nrst;
    logic       pos_dir;
    logic       neg_dir;
    logic [7:0] angle;
    logic [7:0] target;
    logic       src_cmd;
    logic       at_target;

    int checks = 0;
    int errors = 0;

    servo_steer_ctrl_if cmd_if ();

    servo_steer_ctrl #(
        .CLK_DIV    (4),
        .STEP       (8'd2),
        .HOLD_TICKS (16'd5)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .pos_dir   (pos_dir),
        .neg_dir   (neg_dir),
        .cmd       (cmd_if.slave),
        .angle     (angle),
        .target    (target),
        .src_cmd   (src_cmd),
        .at_target (at_target)
    );

    always #5 clk = ~clk;

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until_angle(input logic [7:0] exp, input int bound, output bit ok);
        int n;
        n = 0;
        while (angle !== exp && n < bound) begin
            step_cycle();
            n++;
        end
        ok = (angle === exp);
    endtask

    task automatic wait_src_low(input int bound, output bit ok);
        int n;
        n = 0;
        while (src_cmd !== 1'b0 && n < bound) begin
            step_cycle();
            n++;
        end
        ok = (src_cmd === 1'b0);
    endtask

    task automatic test_reset();
        nrst = 1'b0; pos_dir = 1'b0; neg_dir = 1'b0;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_angle = 8'd0; cmd_if.cmd_release = 1'b0;
        #12;
        checks++; if (angle !== 8'd90)    begin errors++; $display("FAIL reset_angle: got %0d want 90", angle); end
        checks++; if (target !== 8'd90)   begin errors++; $display("FAIL reset_target: got %0d want 90", target); end
        checks++; if (src_cmd !== 1'b0)   begin errors++; $display("FAIL reset_src: got %0b want 0", src_cmd); end
        checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL reset_at_target: got %0b want 1", at_target); end
        checks++; if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", cmd_if.cmd_ready); end
        @(negedge clk);
        nrst = 1'b1;
        step_cycle();
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %0b want 1", cmd_if.cmd_ready); end
    endtask

    task automatic test_manual_ramp();
        bit ok;
        pos_dir = 1'b1;
        step_cycle();
        checks++; if (target !== 8'd110) begin errors++; $display("FAIL pos_target: got %0d want 110", target); end
        for (int k = 1; k <= 10; k++) begin
            wait_until_angle(8'(90 + 2 * k), 8, ok);
            checks++; if (!ok) begin errors++; $display("FAIL ramp_step%0d: got %0d want %0d", k, angle, 90 + 2 * k); end
            if (k == 9) begin
                checks++; if (at_target !== 1'b0) begin errors++; $display("FAIL ramp_at_target9: got %0b want 0", at_target); end
            end
        end
        checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL ramp_at_target10: got %0b want 1", at_target); end
        pos_dir = 1'b0;
        wait_until_angle(8'd90, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL return_center: got %0d want 90", angle); end
    endtask

    task automatic test_priority();
        bit ok;
        pos_dir = 1'b1; neg_dir = 1'b1;
        step_cycle();
        checks++; if (target !== 8'd110) begin errors++; $display("FAIL both_dir_target: got %0d want 110", target); end
        pos_dir = 1'b0;
        step_cycle();
        checks++; if (target !== 8'd70) begin errors++; $display("FAIL neg_target: got %0d want 70", target); end
        neg_dir = 1'b0;
        wait_until_angle(8'd90, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL priority_settle: got %0d want 90", angle); end
    endtask

    task automatic test_cmd_clamp_timeout();
        bit ok;
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_angle = 8'd200;
        step_cycle();
        cmd_if.cmd_valid = 1'b0;
        neg_dir = 1'b1;
        checks++; if (target !== 8'd120)  begin errors++; $display("FAIL clamp_hi_target: got %0d want 120", target); end
        checks++; if (src_cmd !== 1'b1)   begin errors++; $display("FAIL clamp_hi_src: got %0b want 1", src_cmd); end
        checks++; if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL clamp_hi_ready: got %0b want 0", cmd_if.cmd_ready); end
        step_cycle();
        checks++; if (target !== 8'd120) begin errors++; $display("FAIL cmd_ignores_manual: got %0d want 120", target); end
        wait_until_angle(8'd92, 8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL cmd_ramp_first: got %0d want 92", angle); end
        checks++; if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_mid_ramp: got %0b want 0", cmd_if.cmd_ready); end
        wait_src_low(60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hold_timeout: src_cmd %0b want 0", src_cmd); end
        checks++; if (angle !== 8'd100) begin errors++; $display("FAIL timeout_angle: got %0d want 100", angle); end
        checks++; if (target !== 8'd70) begin errors++; $display("FAIL timeout_manual_target: got %0d want 70", target); end
        wait_until_angle(8'd70, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL reach_neg: got %0d want 70", angle); end
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_angle = 8'd10;
        step_cycle();
        cmd_if.cmd_valid = 1'b0;
        neg_dir = 1'b0;
        checks++; if (target !== 8'd60) begin errors++; $display("FAIL clamp_lo_target: got %0d want 60", target); end
        checks++; if (src_cmd !== 1'b1) begin errors++; $display("FAIL clamp_lo_src: got %0b want 1", src_cmd); end
        wait_src_low(60, ok);
        checks++; if (!ok || target !== 8'd90) begin errors++; $display("FAIL clamp_lo_timeout: src %0b target %0d want 0/90", src_cmd, target); end
        wait_until_angle(8'd90, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clamp_lo_settle: got %0d want 90", angle); end
    endtask

    task automatic test_no_overshoot();
        bit ok;
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_angle = 8'd91;
        step_cycle();
        cmd_if.cmd_valid = 1'b0;
        wait_until_angle(8'd91, 8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL partial_step_up: got %0d want 91", angle); end
        checks++; if (at_target !== 1'b1 || cmd_if.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL at_91_flags: at_target %0b ready %0b want 1/1", at_target, cmd_if.cmd_ready);
        end
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_angle = 8'd90;
        step_cycle();
        cmd_if.cmd_valid = 1'b0;
        checks++; if (target !== 8'd90 || src_cmd !== 1'b1) begin
            errors++; $display("FAIL reload_target: target %0d src %0b want 90/1", target, src_cmd);
        end
        wait_until_angle(8'd90, 8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL no_overshoot: got %0d want 90", angle); end
        checks++; if (at_target !== 1'b1) begin errors++; $display("FAIL no_overshoot_at_target: got %0b want 1", at_target); end
    endtask

    task automatic test_release_drop();
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_before_release: got %0b want 1", cmd_if.cmd_ready); end
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_angle = 8'd120; cmd_if.cmd_release = 1'b1;
        step_cycle();
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_release = 1'b0;
        checks++; if (src_cmd !== 1'b0) begin errors++; $display("FAIL release_src: got %0b want 0", src_cmd); end
        checks++; if (target !== 8'd90) begin errors++; $display("FAIL release_drops_cmd: got %0d want 90", target); end
        step_cycle();
        checks++; if (target !== 8'd90 || src_cmd !== 1'b0) begin
            errors++; $display("FAIL release_stays_manual: target %0d src %0b want 90/0", target, src_cmd);
        end
    endtask

    task automatic test_reset_mid_ramp();
        bit ok;
        pos_dir = 1'b1;
        wait_until_angle(8'd100, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL reach_100: got %0d want 100", angle); end
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_angle = 8'd120;
        step_cycle();
        cmd_if.cmd_valid = 1'b0;
        checks++; if (src_cmd !== 1'b1 || angle !== 8'd100) begin
            errors++; $display("FAIL pre_reset_state: src %0b angle %0d want 1/100", src_cmd, angle);
        end
        nrst = 1'b0;
        pos_dir = 1'b0;
        #1;
        checks++; if (angle !== 8'd90)  begin errors++; $display("FAIL async_reset_angle: got %0d want 90", angle); end
        checks++; if (target !== 8'd90) begin errors++; $display("FAIL async_reset_target: got %0d want 90", target); end
        checks++; if (src_cmd !== 1'b0) begin errors++; $display("FAIL async_reset_src: got %0b want 0", src_cmd); end
        checks++; if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL async_reset_ready: got %0b want 0", cmd_if.cmd_ready); end
        @(negedge clk);
        nrst = 1'b1;
        step_cycle();
        checks++; if (cmd_if.cmd_ready !== 1'b1 || angle !== 8'd90) begin
            errors++; $display("FAIL reset_recover: ready %0b angle %0d want 1/90", cmd_if.cmd_ready, angle);
        end
    endtask

    initial begin
        test_reset();
        test_manual_ramp();
        test_priority();
        test_cmd_clamp_timeout();
        test_no_overshoot();
        test_release_drop();
        test_reset_mid_ramp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
